// File: rtl/bank_isu_issue_sched.sv
// rtl/bank_isu_issue_sched.sv - Oldest-first issue scheduler for the bank issue queue
// Registered issue slot, per-channel in-flight read tracking and credit-release pulses.
module bank_isu_issue_sched #(
  parameter int CHANNEL_NUM = 3,
  parameter int PTR_WIDTH   = 8,
  parameter int DEPTH       = 1 << PTR_WIDTH,
  parameter int MAX_CREDIT  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH-1:0]       iq_valid_array,
  input  logic [DEPTH-1:0]       credit_allow_array,
  input  logic [DEPTH-1:0]       iq_read_array,
  input  logic [2*DEPTH-1:0]     ch_id_flat,
  input  logic [PTR_WIDTH-1:0]   iq_bottom_ptr,
  input  logic                   iq_dequeue,
  input  logic [PTR_WIDTH-1:0]   iq_dequeue_ptr,
  input  logic                   flush,
  input  logic [CHANNEL_NUM-1:0] ch_ready,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [PTR_WIDTH-1:0]   issue_ptr,
  output logic [1:0]             issue_ch_id,
  output logic                   issue_is_read,
  input  logic [CHANNEL_NUM-1:0] rsp_valid,
  output logic [CHANNEL_NUM-1:0] channels_credit_release,
  output logic                   inflight_err
);

  localparam int CW = $clog2(MAX_CREDIT + 1);

  logic [DEPTH-1:0]       issued_q;
  logic [DEPTH-1:0]       elig;
  logic [3:0]             ready_pad;
  logic [PTR_WIDTH-1:0]   sel;
  logic                   found;
  logic                   dq_hit;
  logic                   load;
  logic                   accept;
  logic [CW-1:0]          inflight [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] inc;
  logic [CHANNEL_NUM-1:0] ovf;
  logic [CHANNEL_NUM-1:0] unf;

  // Unused channel slots read as not-ready so out-of-range ch_id never qualifies.
  always_comb begin
    ready_pad = '0;
    ready_pad[CHANNEL_NUM-1:0] = ch_ready;
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = iq_valid_array[i] & credit_allow_array[i] & ~issued_q[i]
              & (32'(ch_id_flat[2*i +: 2]) < CHANNEL_NUM)
              & ready_pad[ch_id_flat[2*i +: 2]];
    end
  end

  // Rotating priority scan: pointer arithmetic wraps naturally at DEPTH.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx;
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = iq_bottom_ptr + PTR_WIDTH'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign dq_hit = iq_dequeue & (iq_dequeue_ptr == sel);
  assign load   = ~flush & found & (~issue_valid | issue_ready) & ~dq_hit;
  assign accept = issue_valid & issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
    end else if (flush) begin
      issued_q <= '0;
    end else begin
      if (iq_dequeue) issued_q[iq_dequeue_ptr] <= 1'b0;
      if (load)       issued_q[sel]            <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid   <= 1'b0;
      issue_ptr     <= '0;
      issue_ch_id   <= '0;
      issue_is_read <= 1'b0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (load) begin
      issue_valid   <= 1'b1;
      issue_ptr     <= sel;
      issue_ch_id   <= ch_id_flat[2*sel +: 2];
      issue_is_read <= iq_read_array[sel];
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

  // Counters follow the downstream handshake only; flush does not touch them.
  always_comb begin
    inc = '0;
    ovf = '0;
    unf = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      inc[c] = accept & issue_is_read & (32'(issue_ch_id) == c);
      ovf[c] = inc[c] & ~rsp_valid[c] & (inflight[c] == CW'(MAX_CREDIT));
      unf[c] = rsp_valid[c] & ~inc[c] & (inflight[c] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_NUM; c++) inflight[c] <= '0;
      channels_credit_release <= '0;
      inflight_err            <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (inc[c] & ~rsp_valid[c] & ~ovf[c])
          inflight[c] <= inflight[c] + 1'b1;
        else if (rsp_valid[c] & ~inc[c] & ~unf[c])
          inflight[c] <= inflight[c] - 1'b1;
      end
      channels_credit_release <= rsp_valid;
      if ((|ovf) | (|unf)) inflight_err <= 1'b1;
    end
  end

endmodule

// File: doc/bank_isu_issue_sched.md
Name: bank_isu_issue_sched

Overview:
- Issue scheduler for the bank issue queue (IQ). Each cycle it picks the oldest IQ entry that is valid, holds a credit, is not yet issued, and targets a ready channel.
- The selected entry goes into a registered issue slot with a valid/ready handshake toward the channel datapath.
- It tracks in-flight reads per channel and turns channel read responses into one-cycle credit-release pulses for the credit manager.
- It sits between the IQ/credit manager and the per-channel request ports.

Parameters:
- CHANNEL_NUM, 3, number of downstream channels (max 4; ch_id is 2 bits).
- PTR_WIDTH, 8, IQ pointer width.
- DEPTH, 1<<PTR_WIDTH, IQ entry count.
- MAX_CREDIT, 8, per-channel read credit limit; bounds the in-flight counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- iq_valid_array  input  DEPTH  entry valid
- credit_allow_array  input  DEPTH  entry holds a credit
- iq_read_array  input  DEPTH  entry is a read
- ch_id_flat  input  2*DEPTH  channel id of entry i at bits [2i+1:2i]
- iq_bottom_ptr  input  PTR_WIDTH  oldest IQ entry
- iq_dequeue  input  1  IQ frees an entry this cycle
- iq_dequeue_ptr  input  PTR_WIDTH  index of freed entry
- flush  input  1  synchronous flush
- ch_ready  input  CHANNEL_NUM  channel can take a request
- issue_valid  output  1  issue slot holds a request
- issue_ready  input  1  downstream accepts
- issue_ptr  output  PTR_WIDTH  IQ index issued
- issue_ch_id  output  2  target channel
- issue_is_read  output  1  request is a read
- rsp_valid  input  CHANNEL_NUM  read response returned, per channel
- channels_credit_release  output  CHANNEL_NUM  one-cycle credit return pulse
- inflight_err  output  1  sticky protocol error

Behaviour:
- Reset values: issue_valid=0, issue_ptr=0, issue_ch_id=0, issue_is_read=0, channels_credit_release=0, inflight_err=0, issued_q=0, all inflight counters=0.
- Eligibility: elig[i] = iq_valid[i] & credit_allow[i] & ~issued_q[i] & (ch_id[i] < CHANNEL_NUM) & ch_ready[ch_id[i]].
- Selection: the first set bit of elig, scanning from iq_bottom_ptr upward and wrapping DEPTH-1 -> 0. The selection is combinational.
- Slot load condition: load = ~flush & (|elig) & (~issue_valid | issue_ready).
- On load, the slot registers ptr, ch_id and is_read, issue_valid=1 next cycle, and issued_q[sel] is set. The load latency is one cycle.
- Back-to-back issue: if the slot is accepted and reloaded in the same cycle, one request is accepted per cycle with no bubble.
- Hold: while issue_valid & ~issue_ready, the slot outputs stay stable and no new selection is loaded.
- Accept with no eligible entry: issue_valid goes to 0.
- Late ch_ready drop: a channel dropping ch_ready after its entry is loaded does not revoke the loaded request.
- Dequeue: iq_dequeue clears issued_q[iq_dequeue_ptr].
  - If the dequeued index equals the index being selected in the same cycle, dequeue wins: that load is suppressed and the slot stays empty unless it is held.
- Flush:
  - Clears all issued_q bits and issue_valid; issue_ptr, issue_ch_id and issue_is_read keep their values.
  - Has priority over load, accept and dequeue.
  - Does not alter the inflight counters or credit-release logic.
- Inflight counter, per channel (width clog2(MAX_CREDIT+1)):
  - Increments on an accepted read (issue_valid & issue_ready & issue_is_read) to that channel.
  - Decrements on rsp_valid[ch].
  - Both in the same cycle leaves it unchanged.
- Credit release: channels_credit_release[ch] = registered rsp_valid[ch]. One-cycle latency, one pulse per response, no coalescing.
- inflight_err is set, and stays set until reset, when either:
  - rsp_valid[ch] arrives with counter==0 and no same-cycle increment (the counter saturates at 0), or
  - an increment would exceed MAX_CREDIT (the counter saturates at MAX_CREDIT).
- Reset mid-operation: all state returns to reset values asynchronously, and in-flight requests are forgotten.

Test Plan:
- Entries 5, 6 and 7 eligible, bottom_ptr=6, issue_ready=1 -> issue_ptr sequence 6, 7, 5 on consecutive cycles with issue_valid held high.
- Entry 3 eligible, issue_ready=0 for 4 cycles -> issue_ptr=3 stable for those 4 cycles and entry 4 (also eligible) is not loaded; after issue_ready=1, entry 4 appears the next cycle.
- Entry 10 has ch_id=2 with ch_ready[2]=0 and entry 11 has ch_id=0 -> 11 issued first; raising ch_ready[2] -> 10 issued next.
- Entry 9 is accepted, then iq_dequeue_ptr=9 while the IQ re-enqueues index 9 -> entry 9 is eligible and issued again; a dequeue of 9 coinciding with its selection -> issue_valid stays 0 that cycle.
- 8 accepted reads on ch1, then rsp_valid[1] 8 times -> channels_credit_release[1] pulses 8 times, each one cycle after its rsp, and the counter returns to 0; a 9th rsp -> inflight_err=1.
- flush while issue_valid=1 and issued_q is non-zero -> next cycle issue_valid=0 and all previously issued valid entries are reselected in oldest-first order.
